// File: rtl/mcpu_pkg.sv
// Shared types and constants for the multi-cycle CPU: opcodes, FSM states
// and instruction field positions.
package mcpu_pkg;

    typedef enum logic [3:0] {
        OP_AND  = 4'd0,
        OP_OR   = 4'd1,
        OP_ADD  = 4'd2,
        OP_SUB  = 4'd3,
        OP_XOR  = 4'd4,
        OP_LD   = 4'd5,
        OP_ST   = 4'd6,
        OP_LDI  = 4'd7,
        OP_BEQZ = 4'd8,
        OP_JMP  = 4'd9,
        OP_HALT = 4'd10
    } opcode_t;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_HALT
    } state_t;

    // Instruction field positions (16-bit instruction word)
    localparam int OP_MSB    = 15;
    localparam int OP_LSB    = 12;
    localparam int RD_MSB    = 11;
    localparam int RD_LSB    = 9;
    localparam int RS1_MSB   = 8;
    localparam int RS1_LSB   = 6;
    localparam int RS2_MSB   = 5;
    localparam int RS2_LSB   = 3;
    localparam int IMM6_MSB  = 5;
    localparam int IMM9_MSB  = 8;
    localparam int IMM12_MSB = 11;

    // Opcodes 0-4 go through the ALU and are the only ones that touch the flags
    function automatic logic is_alu_op(input logic [3:0] op);
        return (op <= 4'd4);
    endfunction

endpackage

// File: rtl/mcpu_alu.sv
// Combinational ALU: AND/OR/ADD/SUB/XOR with zero, carry/borrow and
// negative flags. Other opcodes yield zero with all flags derived from it.
module mcpu_alu
    import mcpu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  opcode_t           op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] res,
    output logic              zero,
    output logic              carry,
    output logic              negative
);

    logic [DATA_W:0] wide;

    // One extra bit holds the carry-out of ADD or the borrow of SUB
    always_comb begin
        wide = '0;
        case (op)
            OP_AND:  wide = {1'b0, a & b};
            OP_OR:   wide = {1'b0, a | b};
            OP_ADD:  wide = {1'b0, a} + {1'b0, b};
            OP_SUB:  wide = {1'b0, a} - {1'b0, b};
            OP_XOR:  wide = {1'b0, a ^ b};
            default: wide = '0;
        endcase
        res      = wide[DATA_W-1:0];
        carry    = wide[DATA_W];
        zero     = (res == '0);
        negative = res[DATA_W-1];
    end

endmodule

// File: rtl/multicycle_cpu.sv
// Multi-cycle CPU top: FSM, register file, PC and the ALU instance.
// Optional build macro MCPU_R0_ZERO_EN: R0 reads as zero and ignores writes.
//
// Data memory handshake: dmem_req rises on entry to MEM and stays high, with
// dmem_we/dmem_addr/dmem_wdata frozen, until the cycle dmem_ack is sampled
// high; that cycle completes the transfer (load data taken from dmem_rdata)
// and req drops on the following edge. dmem_ack outside MEM is ignored.
module multicycle_cpu
    import mcpu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int PC_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [15:0]       imem_rdata,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              carry,
    output logic              negative,
    output logic              retire,
    output logic              halted,
    output state_t            dbg_state
);

`ifdef MCPU_R0_ZERO_EN
    localparam bit R0_ZERO = 1'b1;
`else
    localparam bit R0_ZERO = 1'b0;
`endif

    state_t            state, state_next;
    logic [PC_W-1:0]   pc, pc_inc, br_target, jmp_target;
    logic [15:0]       ir;
    logic [DATA_W-1:0] regs [8];
    logic [DATA_W-1:0] mem_addr_q, mem_wdata_q;
    logic              mem_we_q;
    opcode_t           op;
    logic [2:0]        rd, rs1, rs2;
    logic [DATA_W-1:0] rs1_val, rs2_val, ldi_val;
    logic [DATA_W-1:0] alu_res, wr_val;
    logic              alu_zero, alu_carry, alu_negative;
    logic              wr_en, is_mem;

    assign op  = opcode_t'(ir[OP_MSB:OP_LSB]);
    assign rd  = ir[RD_MSB:RD_LSB];
    assign rs1 = ir[RS1_MSB:RS1_LSB];
    assign rs2 = ir[RS2_MSB:RS2_LSB];

    assign is_mem     = (op == OP_LD) || (op == OP_ST);
    assign pc_inc     = pc + PC_W'(1);
    assign br_target  = pc_inc + PC_W'($signed(ir[IMM6_MSB:0]));
    assign jmp_target = PC_W'(ir[IMM12_MSB:0]);
    assign ldi_val    = DATA_W'(ir[IMM9_MSB:0]);

    assign imem_addr  = pc;
    assign dmem_req   = (state == S_MEM);
    assign dmem_we    = mem_we_q;
    assign dmem_addr  = mem_addr_q;
    assign dmem_wdata = mem_wdata_q;
    assign halted     = (state == S_HALT);
    assign dbg_state  = state;

    mcpu_alu #(.DATA_W(DATA_W)) u_alu (
        .op       (op),
        .a        (rs1_val),
        .b        (rs2_val),
        .res      (alu_res),
        .zero     (alu_zero),
        .carry    (alu_carry),
        .negative (alu_negative)
    );

    // Register read ports, with R0 forced to zero when that build option is on
    always_comb begin
        rs1_val = regs[rs1];
        rs2_val = regs[rs2];
        if (R0_ZERO && rs1 == 3'd0) rs1_val = '0;
        if (R0_ZERO && rs2 == 3'd0) rs2_val = '0;
    end

    // Select the register write-back source for this cycle
    always_comb begin
        wr_en  = 1'b0;
        wr_val = alu_res;
        if (state == S_EXEC && is_alu_op(ir[OP_MSB:OP_LSB])) begin
            wr_en = 1'b1;
        end else if (state == S_EXEC && op == OP_LDI) begin
            wr_en  = 1'b1;
            wr_val = ldi_val;
        end else if (state == S_MEM && dmem_ack && !mem_we_q) begin
            wr_en  = 1'b1;
            wr_val = dmem_rdata;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_FETCH;
        else       state <= state_next;
    end

    // FSM next state and the retire pulse
    always_comb begin
        state_next = state;
        retire     = 1'b0;
        case (state)
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: state_next = S_EXEC;
            S_EXEC: begin
                if (is_mem) begin
                    state_next = S_MEM;
                end else if (op == OP_HALT) begin
                    state_next = S_HALT;
                    retire     = 1'b1;
                end else begin
                    state_next = S_FETCH;
                    retire     = 1'b1;
                end
            end
            S_MEM: begin
                if (dmem_ack) begin
                    state_next = S_FETCH;
                    retire     = 1'b1;
                end
            end
            S_HALT:   state_next = S_HALT;
            default:  state_next = S_FETCH;
        endcase
    end

    // Register file; R0 writes dropped when R0 is hard-wired to zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) regs[i] <= '0;
        end else if (wr_en && !(R0_ZERO && rd == 3'd0)) begin
            regs[rd] <= wr_val;
        end
    end

    // PC, IR, result, flags and the frozen memory request fields
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc          <= '0;
            ir          <= '0;
            result      <= '0;
            zero        <= 1'b0;
            carry       <= 1'b0;
            negative    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
        end else begin
            if (wr_en) result <= wr_val;
            case (state)
                S_DECODE: ir <= imem_rdata;
                S_EXEC: begin
                    if (is_alu_op(ir[OP_MSB:OP_LSB])) begin
                        zero     <= alu_zero;
                        carry    <= alu_carry;
                        negative <= alu_negative;
                    end
                    case (op)
                        OP_LD, OP_ST: begin
                            // Address captured here, so LD rd==rs1 is safe
                            mem_addr_q  <= rs1_val;
                            mem_wdata_q <= rs2_val;
                            mem_we_q    <= (op == OP_ST);
                        end
                        OP_HALT: begin end
                        OP_BEQZ: pc <= (rs1_val == '0) ? br_target : pc_inc;
                        OP_JMP:  pc <= jmp_target;
                        default: pc <= pc_inc;
                    endcase
                end
                S_MEM: if (dmem_ack) pc <= pc_inc;
                default: begin end
            endcase
        end
    end

endmodule

// File: doc/multicycle_cpu.md
Name: multicycle_cpu

Overview:
Parametrised multi-cycle successor to the 8-bit single-cycle CPU.
- Data width and PC width are configurable.
- Eight registers, 16-bit instructions.
- Instruction memory is a synchronous-read port; data memory sits behind a req/ack handshake.
- Adds an explicit FSM, immediate loads, a conditional branch, a jump, HALT, and registered flags.

Parameters:
DATA_W, 8, datapath/register width (>=4)
PC_W, 8, program counter / instruction address width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
imem_addr  out  PC_W  instruction address (=pc)
imem_rdata  in  16  instruction, valid one cycle after imem_addr
dmem_req  out  1  data request, held until ack
dmem_we  out  1  1=store, 0=load; valid with req
dmem_addr  out  DATA_W  = R[rs1]
dmem_wdata  out  DATA_W  = R[rs2]
dmem_rdata  in  DATA_W  load data, valid when dmem_ack=1
dmem_ack  in  1  one-cycle completion pulse
result  out  DATA_W  last value written to any register
zero, carry, negative  out  1  registered ALU flags
retire  out  1  one-cycle pulse per completed instruction
halted  out  1  high in HALT state

Behaviour:
- Instruction fields:
  - op[15:12], rd[11:9], rs1[8:6], rs2[5:3]
  - imm6[5:0], signed
  - imm9[8:0], unsigned
  - imm12[11:0]
- Opcodes:
  - 0 AND, 1 OR, 2 ADD, 3 SUB, 4 XOR: rd = rs1 op rs2
  - 5 LD: rd = mem[R[rs1]]
  - 6 ST: mem[R[rs1]] = R[rs2]
  - 7 LDI: rd = zext(imm9), truncated to DATA_W
  - 8 BEQZ: if R[rs1]==0 then pc = pc+1+sext(imm6), else pc+1
  - 9 JMP: pc = imm12[PC_W-1:0]
  - 10 HALT
  - 11-15: NOP
- Reset (asynchronous):
  - pc=0, ir=0, all registers=0, flags=0, result=0
  - dmem_req=0, retire=0, halted=0
  - state=FETCH
- FSM states and transitions:
  - FETCH: imem_addr=pc → DECODE.
  - DECODE: ir<=imem_rdata → EXEC.
  - EXEC, ALU/LDI/NOP/branch/jump: write rd and result, update pc, pulse retire → FETCH.
  - EXEC, LD/ST: → MEM.
  - EXEC, HALT: retire → HALT.
  - MEM: dmem_req=1, address/data/we held stable until dmem_ack. On ack: LD writes rd and result; pc+1; retire → FETCH.
  - HALT: absorbing; only reset exits.
- Latency: ALU/LDI/branch/jump/NOP = 3 cycles; LD/ST = 3 + (cycles until ack), minimum 4.
- Arithmetic is DATA_W-wide, modulo 2^DATA_W.
- Flags:
  - Updated only by opcodes 0-4; all other opcodes hold the flags.
  - zero = (res==0); negative = res[DATA_W-1].
  - carry = carry-out for ADD, borrow (A<B unsigned) for SUB, 0 for logic ops.
- PC arithmetic:
  - pc+1 wraps modulo 2^PC_W.
  - Branch offset is sign-extended to PC_W; the sum wraps.
- LD where rd==rs1: the address is captured at MEM entry; the write happens on ack.
- A dmem_ack outside MEM is ignored.
- Reset in MEM drops dmem_req asynchronously; a pending store is abandoned.

Optional Feature:
MCPU_R0_ZERO_EN
- Defined: R0 always reads 0 and writes to R0 are discarded. result and the flags still reflect the computed value.
- Undefined: R0 is an ordinary register.

Decomposition:
- Package mcpu_pkg holds:
  - opcode enum (OP_AND..OP_HALT)
  - state enum (S_FETCH, S_DECODE, S_EXEC, S_MEM, S_HALT)
  - instruction field position constants
- Sub-module mcpu_alu, parametrised DATA_W: combinational op/A/B → res, zero, carry, negative.
- The FSM, register file and PC stay in the top module.

Test Plan:
- ALU and flags, DATA_W=8: LDI R1,200; LDI R2,100; ADD R3,R1,R2 → R3=44, carry=1, zero=0, negative=0. Each instruction retires 3 cycles apart.
- SUB borrow and zero: SUB R4,R2,R1 → R4=156, carry=1, negative=1. SUB R5,R2,R2 → R5=0, zero=1, carry=0.
- Memory handshake: ST [R1],R2 with ack held off 3 cycles → req/we/addr=200/wdata=100 stable for 3 cycles, retire in the ack cycle. Then LD R6,[R1] → R6=100, result=100.
- Branch and jump: R7=0; BEQZ R7,-3 at pc=10 → next fetch at pc=8. JMP 255 followed by a fall-through instruction → pc wraps to 0.
- HALT and reset: HALT → halted=1, imem_addr frozen, no further retire pulses. Async reset mid-MEM → dmem_req=0 immediately; fetch restarts at pc=0.
- MCPU_R0_ZERO_EN: LDI R0,5; ADD R1,R0,R0 → with macro R1=0, result=0; without macro R1=10.
